// File: rtl/loader_pkg.sv
// Shared types and helpers for the boot-time IMEM loader.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR   = 3'd0,
    ST_DATA  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CSUM  = 3'd3,
    ST_RUN   = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  // XOR of the bytes of one word; chaining per word equals the per-byte XOR of the frame
  function automatic logic [7:0] xor_fold(input logic [WORD_W-1:0] word);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      acc = acc ^ word[i*8 +: 8];
    end
    return acc;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs accepted bytes little-endian into a word and keeps the running frame XOR.
module byte_packer
  import loader_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_byte,
  input  logic              i_accept,
  input  logic              i_clear,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_done,
  output logic [7:0]        o_xor
);

  logic [1:0]        r_idx;
  logic [WORD_W-1:0] r_shift;
  logic [7:0]        r_xor;
  logic [WORD_W-1:0] w_merged;

  // o_word already contains the byte being accepted, so the top can capture it on word_done
  always_comb begin
    w_merged = r_shift;
    w_merged[{r_idx, 3'b000} +: 8] = i_byte;
  end

  assign o_word      = w_merged;
  assign o_word_done = i_accept & (r_idx == 2'd3);
  assign o_xor       = r_xor;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_idx   <= 2'd0;
      r_shift <= {WORD_W{1'b0}};
      r_xor   <= 8'h00;
    end else if (i_accept) begin
      r_idx   <= r_idx + 2'd1;
      r_shift <= w_merged;
      if (r_idx == 2'd3) begin
        r_xor <= r_xor ^ xor_fold(w_merged);
      end else begin
        r_xor <= r_xor;
      end
    end else begin
      r_idx   <= r_idx;
      r_shift <= r_shift;
      r_xor   <= r_xor;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader that fills the core IMEM and releases the core on a good checksum.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte_data,
  output logic              o_byte_ready,
  input  logic              i_load_req,
  output logic              o_inst_wen,
  output logic [ADDR_W-1:0] o_inst_addr,
  output logic [WORD_W-1:0] o_inst_data,
  output logic              o_enb,
  output logic              o_busy,
  output logic              o_err
);

  localparam logic [31:0] CAPACITY = 32'd1 << ADDR_W;

  state_e            r_state;
  state_e            w_next;
  logic [7:0]        r_len;
  logic [ADDR_W-1:0] r_word_cnt;
  logic              r_byte_ready, r_inst_wen, r_enb, r_busy, r_err;
  logic [ADDR_W-1:0] r_inst_addr;
  logic [WORD_W-1:0] r_inst_data;
  logic              w_ready_nxt, w_wen_nxt, w_enb_nxt, w_busy_nxt, w_err_nxt;

  logic              w_accept, w_hdr_accept, w_data_accept, w_len_bad, w_last_word;
  logic [WORD_W-1:0] w_word;
  logic              w_word_done;
  logic [7:0]        w_xor;

  // A byte handshaked together with load_req is dropped
  assign w_accept      = i_byte_valid & r_byte_ready & ~i_load_req;
  assign w_hdr_accept  = w_accept & (r_state == ST_HDR);
  assign w_data_accept = w_accept & (r_state == ST_DATA);
  assign w_len_bad     = ({24'd0, i_byte_data} >= CAPACITY);
  assign w_last_word   = ({{(32-ADDR_W){1'b0}}, r_word_cnt} == {24'd0, r_len});

  byte_packer u_packer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_byte      (i_byte_data),
    .i_accept    (w_data_accept),
    .i_clear     (w_hdr_accept | i_load_req),
    .o_word      (w_word),
    .o_word_done (w_word_done),
    .o_xor       (w_xor)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_HDR;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (i_load_req) begin
      w_next = ST_HDR;
    end else begin
      case (r_state)
        ST_HDR:   w_next = w_accept ? (w_len_bad ? ST_ERR : ST_DATA) : ST_HDR;
        ST_DATA:  w_next = w_word_done ? ST_WRITE : ST_DATA;
        ST_WRITE: w_next = w_last_word ? ST_CSUM : ST_DATA;
        ST_CSUM:  w_next = w_accept ? ((i_byte_data == w_xor) ? ST_RUN : ST_ERR) : ST_CSUM;
        ST_RUN:   w_next = ST_RUN;
        ST_ERR:   w_next = ST_ERR;
        default:  w_next = ST_HDR;
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, so they align with the state
  always_comb begin
    w_ready_nxt = 1'b0;
    w_wen_nxt   = 1'b0;
    w_enb_nxt   = 1'b0;
    w_busy_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (w_next)
      ST_HDR:   w_ready_nxt = 1'b1;
      ST_DATA:  begin w_ready_nxt = 1'b1; w_busy_nxt = 1'b1; end
      ST_WRITE: begin w_wen_nxt = 1'b1; w_busy_nxt = 1'b1; end
      ST_CSUM:  begin w_ready_nxt = 1'b1; w_busy_nxt = 1'b1; end
      ST_RUN:   w_enb_nxt = 1'b1;
      ST_ERR:   w_err_nxt = 1'b1;
      default:  w_ready_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_len        <= 8'h00;
      r_word_cnt   <= {ADDR_W{1'b0}};
      r_inst_addr  <= {ADDR_W{1'b0}};
      r_inst_data  <= {WORD_W{1'b0}};
      r_byte_ready <= 1'b1;
      r_inst_wen   <= 1'b0;
      r_enb        <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if (w_hdr_accept) begin
        r_len      <= i_byte_data;
        r_word_cnt <= {ADDR_W{1'b0}};
      end else if (r_state == ST_WRITE) begin
        r_word_cnt <= r_word_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      if (w_word_done) begin
        r_inst_addr <= r_word_cnt;
        r_inst_data <= w_word;
      end
      r_byte_ready <= w_ready_nxt;
      r_inst_wen   <= w_wen_nxt;
      r_enb        <= w_enb_nxt;
      r_busy       <= w_busy_nxt;
      r_err        <= w_err_nxt;
    end
  end

  assign o_byte_ready = r_byte_ready;
  assign o_inst_wen   = r_inst_wen;
  assign o_inst_addr  = r_inst_addr;
  assign o_inst_data  = r_inst_data;
  assign o_enb        = r_enb;
  assign o_busy       = r_busy;
  assign o_err        = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frame table plus abort and reset sequences.
module tb_imem_loader;
  localparam int ADDR_W = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, byte_valid = 1'b0, load_req = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic byte_ready, inst_wen, enb, busy, err;
  logic [ADDR_W-1:0] inst_addr;
  logic [31:0] inst_data;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_byte_valid(byte_valid), .i_byte_data(byte_data),
    .o_byte_ready(byte_ready), .i_load_req(load_req), .o_inst_wen(inst_wen),
    .o_inst_addr(inst_addr), .o_inst_data(inst_data), .o_enb(enb), .o_busy(busy), .o_err(err)
  );

  int n_checks = 0, n_fail = 0, cyc = 0;
  logic [31:0] tx_words [0:255];
  logic [31:0] mem [0:127];
  int wr_count = 0, wr_base = 0, mon_bad = 0;
  logic prev_wen = 1'b0;
  logic [ADDR_W-1:0] last_addr;
  logic [31:0] last_data;

  always @(posedge clk) cyc <= cyc + 1;

  // IMEM model and write-strobe protocol monitor
  always @(negedge clk) begin
    if (inst_wen === 1'b1) begin
      if (byte_ready !== 1'b0 || prev_wen !== 1'b0 ||
          inst_addr !== ADDR_W'(wr_count - wr_base) || inst_data !== tx_words[inst_addr]) begin
        mon_bad++;
        $display("FAIL write_protocol addr=%0d data=%h ready=%b prev_wen=%b expected addr=%0d data=%h",
                 inst_addr, inst_data, byte_ready, prev_wen, ADDR_W'(wr_count - wr_base),
                 tx_words[ADDR_W'(wr_count - wr_base)]);
      end
      mem[inst_addr] = inst_data;
      last_addr = inst_addr;
      last_data = inst_data;
      wr_count++;
    end
    prev_wen = inst_wen;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fill_words(input int pat, input int len);
    logic [31:0] rv [0:2];
    rv[0] = 32'h00500093; rv[1] = 32'h00A00113; rv[2] = 32'h002081B3;
    for (int i = 0; i <= len; i++) begin
      case (pat)
        0:       tx_words[i] = (i == 0) ? 32'h00000013 : 32'h0;
        1:       tx_words[i] = (i < 3) ? rv[i] : 32'h0;
        2:       tx_words[i] = 32'(i);
        default: tx_words[i] = 32'hDEADBEEF ^ (32'(i) * 32'h01010101);
      endcase
    end
  endtask

  function automatic logic [7:0] calc_csum(input int len);
    logic [7:0] x;
    logic [31:0] w;
    x = 8'h00;
    for (int i = 0; i <= len; i++) begin
      w = tx_words[i];
      x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    end
    return x;
  endfunction

  // Offers one byte from the falling edge; returns 1 ns after the accepting rising edge
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit done;
    logic [31:0] w;
    done = 1'b0;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 1) == 1) begin
        byte_valid = 1'b0;
      end else begin
        byte_valid = 1'b1;
        byte_data = b;
        if (byte_ready === 1'b1) begin
          @(posedge clk);
          #1;
          done = 1'b1;
        end
      end
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] len, input logic [7:0] mask, input bit gaps);
    int h, c;
    logic [31:0] w;
    wr_base = wr_count;
    send_byte(len, gaps);
    h = cyc;
    if (len >= 8'h80) begin
      check("busy_bad_hdr", {31'd0, busy}, 32'd0);
    end else begin
      check("busy_after_hdr", {31'd0, busy}, 32'd1);
      for (int i = 0; i <= int'(len); i++) begin
        w = tx_words[i];
        for (int b = 0; b < 4; b++) send_byte(w[b*8 +: 8], gaps);
      end
      send_byte(calc_csum(int'(len)) ^ mask, gaps);
      c = cyc;
      if (!gaps) check("frame_cycles", 32'(c - h), 32'(5 * (int'(len) + 1) + 1));
    end
    byte_valid = 1'b0;
  endtask

  task automatic pulse_load_req(input bit with_byte);
    @(negedge clk);
    load_req = 1'b1;
    if (with_byte) begin
      byte_valid = 1'b1;
      byte_data = 8'h00;
    end
    @(posedge clk);
    #1;
    check("ldreq_enb", {31'd0, enb}, 32'd0);
    check("ldreq_err", {31'd0, err}, 32'd0);
    check("ldreq_busy", {31'd0, busy}, 32'd0);
    check("ldreq_ready", {31'd0, byte_ready}, 32'd1);
    @(negedge clk);
    load_req = 1'b0;
    byte_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0] len;
    logic [7:0] mask;
    int         pat;
    bit         gaps;
    bit         exp_enb;
    bit         exp_err;
    int         exp_wr;
  } vec_t;

  vec_t vecs [0:6];

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, byte_ready}, 32'd1);
    check({tag, "_wen"}, {31'd0, inst_wen}, 32'd0);
    check({tag, "_addr"}, 32'(inst_addr), 32'd0);
    check({tag, "_data"}, inst_data, 32'd0);
    check({tag, "_enb"}, {31'd0, enb}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    int bad;
    logic [31:0] w;
    vecs[0] = '{8'h00, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1};
    vecs[1] = '{8'h02, 8'h00, 1, 1'b1, 1'b1, 1'b0, 3};
    vecs[2] = '{8'h02, 8'h01, 1, 1'b0, 1'b0, 1'b1, 3};
    vecs[3] = '{8'h02, 8'h00, 1, 1'b0, 1'b1, 1'b0, 3};
    vecs[4] = '{8'h7F, 8'h00, 2, 1'b0, 1'b1, 1'b0, 128};
    vecs[5] = '{8'h05, 8'h80, 3, 1'b1, 1'b0, 1'b1, 6};
    vecs[6] = '{8'h80, 8'h00, 3, 1'b0, 1'b0, 1'b1, 0};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-frame, after two words have been written
    fill_words(3, 2);
    wr_base = wr_count;
    send_byte(8'h02, 1'b0);
    for (int k = 0; k < 9; k++) begin
      w = tx_words[k / 4];
      send_byte(w[(k % 4) * 8 +: 8], 1'b0);
    end
    byte_valid = 1'b0;
    check("midrst_writes", 32'(wr_count - wr_base), 32'd2);
    check("midrst_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      pulse_load_req(1'b0);
      fill_words(vecs[v].pat, int'(vecs[v].len));
      send_frame(vecs[v].len, vecs[v].mask, vecs[v].gaps);
      check($sformatf("v%0d_enb", v), {31'd0, enb}, {31'd0, vecs[v].exp_enb});
      check($sformatf("v%0d_err", v), {31'd0, err}, {31'd0, vecs[v].exp_err});
      check($sformatf("v%0d_writes", v), 32'(wr_count - wr_base), 32'(vecs[v].exp_wr));
      if (vecs[v].exp_enb) begin
        bad = 0;
        for (int i = 0; i <= int'(vecs[v].len); i++) if (mem[i] !== tx_words[i]) bad++;
        check($sformatf("v%0d_imem", v), 32'(bad), 32'd0);
        check($sformatf("v%0d_ready_run", v), {31'd0, byte_ready}, 32'd0);
      end
      if (vecs[v].len == 8'h7F) begin
        check("max_last_addr", 32'(last_addr), 32'd127);
        check("max_last_data", last_data, 32'h0000007F);
      end
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("v%0d_hold_enb", v), {31'd0, enb}, {31'd0, vecs[v].exp_enb});
    end

    // Abort in DATA after two of three words, with a byte offered alongside load_req
    pulse_load_req(1'b0);
    fill_words(1, 2);
    wr_base = wr_count;
    send_byte(8'h02, 1'b0);
    for (int k = 0; k < 8; k++) begin
      w = tx_words[k / 4];
      send_byte(w[(k % 4) * 8 +: 8], 1'b0);
    end
    byte_valid = 1'b0;
    @(posedge clk);
    #1;
    check("abort_writes", 32'(wr_count - wr_base), 32'd2);
    pulse_load_req(1'b1);
    @(posedge clk);
    #1;
    check("abort_discard_busy", {31'd0, busy}, 32'd0);
    fill_words(3, 0);
    send_frame(8'h00, 8'h00, 1'b0);
    check("abort_new_enb", {31'd0, enb}, 32'd1);
    check("abort_overwrite", mem[0], 32'hDEADBEEF);
    check("abort_keep_word1", mem[1], 32'h00A00113);

    check("write_monitor", 32'(mon_bad), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
